dau_input_sequencer: RTL and testbench
======================================

Name: dau_input_sequencer

Overview:
Sits between the UART receiver and the decimal arithmetic unit (DAU) of the RPN calculator. Converts each received ASCII byte to a DAU symbol, drops invalid characters and over-long digit runs, buffers accepted symbols in a FIFO, and delivers them to the DAU over a valid/ready handshake. The UART side has no backpressure, so all loss cases are flagged.

Parameters:
DEPTH, 16, FIFO depth in symbols; power of 2, minimum 2.
MAX_DIGITS, 8, maximum consecutive digit symbols forwarded per operand; range 1..255.

Ports:
i_clk  input  1  system clock, all logic on rising edge
i_rst  input  1  synchronous, active-high reset
i_char  input  8  ASCII byte from UART RX
i_char_valid  input  1  one-cycle strobe qualifying i_char
i_flush  input  1  synchronous clear of FIFO and digit-run state
o_symbol  output  5  FIFO head symbol (`DAU_SYM_WIDTH)
o_sym_valid  output  1  FIFO non-empty
i_dau_ready  input  1  DAU accepts o_symbol this cycle
o_count  output  $clog2(DEPTH)+1  current FIFO occupancy
o_invalid  output  1  one-cycle pulse: byte dropped as invalid
o_digit_drop  output  1  one-cycle pulse: digit dropped by run limit
o_overflow  output  1  sticky: symbol lost because FIFO full

Behaviour:
- Reset, registered: FIFO empty, o_count=0, o_sym_valid=0, o_symbol=`DAU_SYM_INVALID (5'h1F), o_invalid=0, o_digit_drop=0, o_overflow=0, FSM=S_IDLE.
- Mapping, combinational on i_char: 8'h0D -> 5'h0D (ENTER); 8'h30..8'h39 -> 5'h10..5'h19; 8'h2B -> 5'h1B (PLUS); 8'h2C -> 5'h1C (COMMA); 8'h2D -> 5'h1D (MINUS); anything else -> 5'h1F (INVALID).
- Invalid byte with i_char_valid: not pushed, o_invalid=1 next cycle, FSM and digit counter unchanged.
- Digit-run FSM, advanced only on valid, non-invalid characters:
  - S_IDLE: digit -> push, cnt=1, go S_NUM (or S_SAT if MAX_DIGITS=1). Non-digit -> push, stay.
  - S_NUM: digit -> push, cnt+1; if cnt+1==MAX_DIGITS go S_SAT. Non-digit -> push, cnt=0, go S_IDLE.
  - S_SAT: digit -> drop, o_digit_drop=1 next cycle, stay. Non-digit -> push, cnt=0, go S_IDLE.
- FIFO is show-ahead. o_symbol = head entry while non-empty, else 5'h1F. Pop when o_sym_valid && i_dau_ready.
- Latency: a byte strobed in cycle k is visible on o_symbol/o_sym_valid in cycle k+1 if the FIFO was empty.
- Full FIFO with a push request:
  - If a pop occurs in the same cycle, the push is accepted and occupancy is unchanged.
  - Otherwise the symbol is discarded and o_overflow is set. The FSM still advances, so the digit count reflects the received stream.
- Empty FIFO with i_dau_ready=1 and no valid data: no pop, no state change.
- Simultaneous push and pop on a non-full FIFO: both occur, o_count unchanged. Read and write pointers wrap modulo DEPTH.
- o_overflow clears only on i_rst or i_flush.
- i_flush, one cycle, priority over push and pop in the same cycle:
  - Next cycle: FIFO empty, FSM=S_IDLE, cnt=0, o_overflow=0, pulse outputs 0.
  - The character strobed in the flush cycle is discarded.
- i_rst has priority over i_flush. Reset mid-stream discards all buffered symbols without a pop.
- DAU handshake: o_symbol stays stable while o_sym_valid=1 and i_dau_ready=0.

Test Plan:
1. Reset, then bytes "12+\r" on consecutive cycles with i_dau_ready=1 -> DAU receives 5'h11, 5'h12, 5'h1B, 5'h0D in order; first o_sym_valid one cycle after the first strobe; no flags.
2. Byte 8'h41 ('A') then '7' -> o_invalid pulses once; only 5'h17 delivered; digit counter starts at 1.
3. MAX_DIGITS=8, bytes "1234567890" then ',' -> eight symbols 5'h11..5'h18 delivered; o_digit_drop pulses twice ('9','0'); 5'h1C delivered; a following '5' is accepted.
4. i_dau_ready=0, 18 digit/op bytes with DEPTH=16 and no run overflow -> o_count saturates at 16, o_overflow set, last two symbols lost. Then i_dau_ready=1 -> exactly 16 symbols drain, o_count reaches 0, o_overflow stays set.
5. FIFO full, push and pop in the same cycle -> push accepted, o_count stays 16, no overflow. Then assert i_flush with i_char_valid=1 -> next cycle o_count=0, o_sym_valid=0, o_overflow=0, flushed byte absent.
6. i_dau_ready toggling every cycle during a 6-symbol burst -> o_symbol held stable while not ready; no symbol duplicated or skipped.

Source files
------------

// File: rtl/dau_input_sequencer.sv
// dau_input_sequencer: ASCII byte -> DAU symbol mapper, digit-run limiter and
// show-ahead symbol FIFO feeding the DAU over a valid/ready handshake.
module dau_input_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned MAX_DIGITS = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [7:0]               i_char,
  input  logic                     i_char_valid,
  input  logic                     i_flush,
  output logic [4:0]               o_symbol,
  output logic                     o_sym_valid,
  input  logic                     i_dau_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_invalid,
  output logic                     o_digit_drop,
  output logic                     o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [4:0]  SYM_ENTER   = 5'h0D;
  localparam logic [4:0]  SYM_PLUS    = 5'h1B;
  localparam logic [4:0]  SYM_COMMA   = 5'h1C;
  localparam logic [4:0]  SYM_MINUS   = 5'h1D;
  localparam logic [4:0]  SYM_INVALID = 5'h1F;

  localparam logic [AW:0] FULL_CNT    = (AW+1)'(DEPTH);
  localparam logic [7:0]  MAXD        = 8'(MAX_DIGITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_NUM,
    S_SAT
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [7:0]      r_cnt;
  logic [7:0]      w_cnt_next;
  logic [7:0]      w_cnt_inc;

  logic [4:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;

  logic            r_invalid;
  logic            r_digit_drop;
  logic            r_overflow;

  logic [4:0]      w_sym;
  logic            w_is_digit;
  logic            w_is_invalid;
  logic            w_accept;
  logic            w_push_req;
  logic            w_drop_digit;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_ovf_event;

  // ASCII to DAU symbol mapping
  always_comb begin
    w_sym      = SYM_INVALID;
    w_is_digit = 1'b0;
    if (i_char >= 8'h30 && i_char <= 8'h39) begin
      w_sym      = {1'b1, i_char[3:0]};
      w_is_digit = 1'b1;
    end else begin
      case (i_char)
        8'h0D:   w_sym = SYM_ENTER;
        8'h2B:   w_sym = SYM_PLUS;
        8'h2C:   w_sym = SYM_COMMA;
        8'h2D:   w_sym = SYM_MINUS;
        default: w_sym = SYM_INVALID;
      endcase
    end
    w_is_invalid = (w_sym == SYM_INVALID);
  end

  assign w_accept  = i_char_valid && !w_is_invalid;
  assign w_cnt_inc = r_cnt + 8'd1;

  // Digit-run FSM: next state, run counter, push/drop decisions
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_push_req   = 1'b0;
    w_drop_digit = 1'b0;
    if (w_accept) begin
      case (r_state)
        S_IDLE: begin
          w_push_req = 1'b1;
          if (w_is_digit) begin
            w_cnt_next   = 8'd1;
            w_state_next = (MAXD == 8'd1) ? S_SAT : S_NUM;
          end else begin
            w_cnt_next   = '0;
          end
        end
        S_NUM: begin
          w_push_req = 1'b1;
          if (w_is_digit) begin
            w_cnt_next = w_cnt_inc;
            if (w_cnt_inc == MAXD) w_state_next = S_SAT;
          end else begin
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
          end
        end
        S_SAT: begin
          if (w_is_digit) begin
            w_drop_digit = 1'b1;
          end else begin
            w_push_req   = 1'b1;
            w_cnt_next   = '0;
            w_state_next = S_IDLE;
          end
        end
        default: begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      endcase
    end
  end

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_pop       = !w_empty && i_dau_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push      = w_push_req && (!w_full || w_pop);
  assign w_ovf_event = w_push_req && w_full && !w_pop;

  // FSM state and run counter
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  // FIFO storage
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && w_push) r_mem[r_wr_ptr] <= w_sym;
  end

  // Status pulses and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_invalid    <= 1'b0;
      r_digit_drop <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_invalid    <= i_char_valid && w_is_invalid;
      r_digit_drop <= w_drop_digit;
      if (w_ovf_event) r_overflow <= 1'b1;
    end
  end

  assign o_symbol     = w_empty ? SYM_INVALID : r_mem[r_rd_ptr];
  assign o_sym_valid  = !w_empty;
  assign o_count      = r_count;
  assign o_invalid    = r_invalid;
  assign o_digit_drop = r_digit_drop;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_dau_input_sequencer.sv
// Bench for dau_input_sequencer: queue-based reference model plus directed
// scenarios with literal expected symbol streams.
module tb_dau_input_sequencer;

  localparam int unsigned DEPTH      = 16;
  localparam int unsigned MAX_DIGITS = 8;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [7:0]  i_char = '0;
  logic        i_char_valid = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_dau_ready = 1'b0;
  logic [4:0]  o_symbol;
  logic        o_sym_valid;
  logic [4:0]  o_count;
  logic        o_invalid;
  logic        o_digit_drop;
  logic        o_overflow;

  dau_input_sequencer #(
    .DEPTH      (DEPTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_char       (i_char),
    .i_char_valid (i_char_valid),
    .i_flush      (i_flush),
    .o_symbol     (o_symbol),
    .o_sym_valid  (o_sym_valid),
    .i_dau_ready  (i_dau_ready),
    .o_count      (o_count),
    .o_invalid    (o_invalid),
    .o_digit_drop (o_digit_drop),
    .o_overflow   (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of symbols, run length, sticky/pulse flags.
  logic [4:0] mq[$];
  int         m_run = 0;
  bit         m_ovf = 0;
  bit         m_inv = 0;
  bit         m_drop = 0;
  bit         m_pop;
  bit         m_req;
  logic [4:0] m_sym;

  always @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      mq.delete();
      m_run  = 0;
      m_ovf  = 0;
      m_inv  = 0;
      m_drop = 0;
    end else begin
      m_pop  = (mq.size() > 0) && i_dau_ready;
      m_req  = 0;
      m_sym  = 5'h1F;
      m_inv  = 0;
      m_drop = 0;
      if (i_char_valid) begin
        if (i_char >= 8'h30 && i_char <= 8'h39) begin
          if (m_run < int'(MAX_DIGITS)) begin
            m_req = 1;
            m_sym = 5'(16 + int'(i_char) - 48);
            m_run++;
          end else begin
            m_drop = 1;
          end
        end else if (i_char == 8'h0D) begin
          m_req = 1; m_sym = 5'h0D; m_run = 0;
        end else if (i_char >= 8'h2B && i_char <= 8'h2D) begin
          m_req = 1; m_sym = 5'(int'(i_char) - 16); m_run = 0;
        end else begin
          m_inv = 1;
        end
      end
      if (m_pop) void'(mq.pop_front());
      if (m_req) begin
        if (mq.size() < int'(DEPTH)) mq.push_back(m_sym);
        else m_ovf = 1;
      end
    end
  end

  // Per-cycle comparison against the model, plus delivery log.
  bit         live = 0;
  bit         prev_valid = 0;
  logic [4:0] prev_sym = '0;
  logic [4:0] got[$];
  int         n_inv = 0;
  int         n_drop = 0;

  always @(negedge i_clk) begin
    if (live) begin
      check("valid",    int'(o_sym_valid),  int'(mq.size() != 0));
      check("symbol",   int'(o_symbol),     (mq.size() != 0) ? int'(mq[0]) : 'h1F);
      check("count",    int'(o_count),      mq.size());
      check("overflow", int'(o_overflow),   int'(m_ovf));
      check("invalid",  int'(o_invalid),    int'(m_inv));
      check("drop",     int'(o_digit_drop), int'(m_drop));
      // i_dau_ready/i_flush still hold the values seen at the last rising edge
      if (prev_valid && !i_dau_ready && !i_flush && !i_rst)
        check("stable", int'(o_symbol), int'(prev_sym));
      if (prev_valid && i_dau_ready && !i_flush && !i_rst)
        got.push_back(prev_sym);
      if (o_invalid) n_inv++;
      if (o_digit_drop) n_drop++;
    end
    prev_valid = o_sym_valid;
    prev_sym   = o_symbol;
  end

  task automatic drive(input logic v, input logic [7:0] c, input logic rdy, input logic fl);
    @(negedge i_clk);
    #1;
    i_char_valid = v;
    i_char       = c;
    i_dau_ready  = rdy;
    i_flush      = fl;
  endtask

  task automatic send_str(input string s, input logic rdy);
    for (int unsigned k = 0; k < s.len(); k++) drive(1'b1, s[k], rdy, 1'b0);
    drive(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, rdy, 1'b0);
  endtask

  task automatic start_test;
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    got.delete();
    n_inv  = 0;
    n_drop = 0;
  endtask

  task automatic check_seq(input string name, input logic [4:0] e[$]);
    check({name, "_len"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++)
      check(name, int'(got[i]), int'(e[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_symbol", int'(o_symbol), 'h1F);
    check("rst_valid",  int'(o_sym_valid), 0);
    check("rst_count",  int'(o_count), 0);
    check("rst_flags",  int'({o_invalid, o_digit_drop, o_overflow}), 0);
    live = 1;

    // 1: "12+\r" with ready high, first valid one cycle after the strobe
    drive(1'b1, "1", 1'b1, 1'b0);
    drive(1'b1, "2", 1'b1, 1'b0);
    check("t1_latency_valid", int'(o_sym_valid), 1);
    check("t1_latency_sym",   int'(o_symbol), 'h11);
    drive(1'b1, "+", 1'b1, 1'b0);
    drive(1'b1, 8'h0D, 1'b1, 1'b0);
    idle(4, 1'b1);
    check_seq("t1_seq", '{5'h11, 5'h12, 5'h1B, 5'h0D});
    check("t1_flags", n_inv + n_drop + int'(o_overflow), 0);

    // 2: invalid byte, then a run whose count starts at the '7'
    start_test();
    send_str("A71234567", 1'b1);
    send_str("8", 1'b1);
    idle(3, 1'b1);
    check_seq("t2_seq", '{5'h17, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17});
    check("t2_inv_pulses", n_inv, 1);
    check("t2_drop_pulses", n_drop, 1);

    // 3: run limit of eight digits
    start_test();
    send_str("1234567890,5", 1'b1);
    idle(3, 1'b1);
    check_seq("t3_seq", '{5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18, 5'h1C, 5'h15});
    check("t3_drop_pulses", n_drop, 2);

    // 4: overflow with ready low, then drain
    start_test();
    send_str("12+34-56,78+90-12+", 1'b0);
    check("t4_count_full", int'(o_count), 16);
    check("t4_ovf_set", int'(o_overflow), 1);
    idle(20, 1'b1);
    check_seq("t4_seq", '{5'h11, 5'h12, 5'h1B, 5'h13, 5'h14, 5'h1D, 5'h15, 5'h16,
                          5'h1C, 5'h17, 5'h18, 5'h1B, 5'h19, 5'h10, 5'h1D, 5'h11});
    check("t4_count_empty", int'(o_count), 0);
    check("t4_ovf_sticky", int'(o_overflow), 1);

    // 5: push+pop on a full FIFO, then flush with a strobed byte
    start_test();
    check("t5_ovf_cleared", int'(o_overflow), 0);
    send_str("12+34+56+78+90+1", 1'b0);
    check("t5_full", int'(o_count), 16);
    drive(1'b1, "2", 1'b1, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_pushpop_count", int'(o_count), 16);
    check("t5_pushpop_ovf", int'(o_overflow), 0);
    check("t5_head_after_pop", int'(o_symbol), 'h12);
    drive(1'b1, "9", 1'b0, 1'b1);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_flush_count", int'(o_count), 0);
    check("t5_flush_valid", int'(o_sym_valid), 0);
    check("t5_flush_ovf", int'(o_overflow), 0);
    idle(1, 1'b0);
    check("t5_flushed_byte_absent", int'(o_count), 0);

    // 6: ready toggling during a six-symbol burst
    start_test();
    drive(1'b1, "4", 1'b0, 1'b0);
    drive(1'b1, "5", 1'b1, 1'b0);
    drive(1'b1, "+", 1'b0, 1'b0);
    drive(1'b1, "6", 1'b1, 1'b0);
    drive(1'b1, "-", 1'b0, 1'b0);
    drive(1'b1, 8'h0D, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b0, 8'h00, 1'(i % 2), 1'b0);
    check_seq("t6_seq", '{5'h14, 5'h15, 5'h1B, 5'h16, 5'h1D, 5'h0D});

    // Reset mid-stream drops buffered symbols
    start_test();
    send_str("123", 1'b0);
    check("rst_mid_pre", int'(o_count), 3);
    @(negedge i_clk);
    #1;
    i_rst = 1'b1;
    @(negedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_mid_count", int'(o_count), 0);
    check("rst_mid_symbol", int'(o_symbol), 'h1F);
    idle(2, 1'b1);
    check("rst_mid_no_delivery", got.size(), 0);

    live = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
